// File: rtl/td4_wide.sv
// TD4-style core: 4-bit opcode ISA over a DW-bit datapath with an AW-bit program counter.
// One instruction retires per clock edge while en is high and the core is not halted.
module td4_wide #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] rom_adr,
  input  logic [DW+3:0] rom_data,
  input  logic [DW-1:0] in_port,
  output logic [DW-1:0] out_port,
  output logic          halted
);

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_AI = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_BI = 4'b0111,
    OP_HLT    = 4'b1000,
    OP_OUT_B  = 4'b1001,
    OP_NOP_A  = 4'b1010,
    OP_OUT_I  = 4'b1011,
    OP_NOP_C  = 4'b1100,
    OP_NOP_D  = 4'b1101,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] out_q, out_d;
  logic          c_q, c_d;
  logic          h_q, h_d;

  opcode_e       opcode;
  logic [DW-1:0] imm;
  logic [DW:0]   sum_a;
  logic [DW:0]   sum_b;

  assign opcode = opcode_e'(rom_data[DW+3:DW]);
  assign imm    = rom_data[DW-1:0];
  assign sum_a  = {1'b0, a_q} + {1'b0, imm};
  assign sum_b  = {1'b0, b_q} + {1'b0, imm};

  always_comb begin
    // NOTE: every variable gets a hold default first, so no path through the case can infer a latch.
    pc_d  = pc_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = c_q;
    h_d   = h_q;
    if (en && !h_q) begin
      pc_d = pc_q + AW'(1);
      c_d  = 1'b0;
      unique case (opcode)
        OP_ADD_A:  {c_d, a_d} = sum_a;
        OP_MOV_AB: a_d = b_q;
        OP_IN_A:   a_d = in_port;
        OP_MOV_AI: a_d = imm;
        OP_MOV_BA: b_d = a_q;
        OP_ADD_B:  {c_d, b_d} = sum_b;
        OP_IN_B:   b_d = in_port;
        OP_MOV_BI: b_d = imm;
        OP_OUT_B:  out_d = b_q;
        OP_OUT_I:  out_d = imm;
        // JNC tests the carry left by the previously executed instruction.
        OP_JNC:    if (!c_q) pc_d = imm[AW-1:0];
        OP_JMP:    pc_d = imm[AW-1:0];
        OP_HLT: begin
          h_d  = 1'b1;
          pc_d = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
      c_q   <= 1'b0;
      h_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
      h_q   <= h_d;
    end
  end

  assign rom_adr  = pc_q;
  assign out_port = out_q;
  assign halted   = h_q;

endmodule

// File: tb/tb_td4_wide.sv
// Self-checking bench for td4_wide: directed vector table, ROM programs, and a
// randomized run compared against an arithmetic instruction-level reference model.
module tb_td4_wide;

  typedef struct {
    int pc;
    int a;
    int b;
    int out;
    int c;
    int h;
  } model_t;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] inp;
    logic       en;
    int         pc;
    int         a;
    int         b;
    int         out;
    int         c;
    int         h;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DW=4, AW=4 instance
  logic       rst4, en4, halt4, rom_mode;
  logic [3:0] adr4, in4, out4;
  logic [7:0] rom_data4, instr4;
  logic [7:0] rom4 [16];

  assign rom_data4 = rom_mode ? rom4[adr4] : instr4;

  td4_wide #(.DW(4), .AW(4)) dut4 (
    .clk      (clk),
    .reset    (rst4),
    .en       (en4),
    .rom_adr  (adr4),
    .rom_data (rom_data4),
    .in_port  (in4),
    .out_port (out4),
    .halted   (halt4)
  );

  // DW=8, AW=6 instance
  logic        rst8, en8, halt8;
  logic [5:0]  adr8;
  logic [7:0]  in8, out8;
  logic [11:0] rom_data8;
  logic [11:0] rom8 [64];

  assign rom_data8 = rom8[adr8];

  td4_wide #(.DW(8), .AW(6)) dut8 (
    .clk      (clk),
    .reset    (rst8),
    .en       (en8),
    .rom_adr  (adr8),
    .rom_data (rom_data8),
    .in_port  (in8),
    .out_port (out8),
    .halted   (halt8)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  model_t m4;
  vec_t   vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Instruction-level behaviour computed with plain integer arithmetic.
  function automatic model_t model_step(input model_t s, input int instr, input int inp,
                                        input bit en, input bit rst, input int dw, input int aw);
    model_t n;
    int     op, im, lim, plim, sum;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0};
      return n;
    end
    if (!en || s.h != 0) return s;
    lim  = 1 << dw;
    plim = 1 << aw;
    op   = (instr >> dw) & 15;
    im   = instr % lim;
    n    = s;
    n.c  = 0;
    n.pc = (s.pc + 1) % plim;
    case (op)
      0:  begin sum = s.a + im; n.a = sum % lim; n.c = (sum >= lim) ? 1 : 0; end
      1:  n.a = s.b;
      2:  n.a = inp;
      3:  n.a = im;
      4:  n.b = s.a;
      5:  begin sum = s.b + im; n.b = sum % lim; n.c = (sum >= lim) ? 1 : 0; end
      6:  n.b = inp;
      7:  n.b = im;
      8:  begin n.h = 1; n.pc = s.pc; end
      9:  n.out = s.b;
      11: n.out = im;
      14: if (s.c == 0) n.pc = im % plim;
      15: n.pc = im % plim;
      default: ;
    endcase
    return n;
  endfunction

  task automatic compare4(input string tag);
    check($sformatf("%s pc", tag),     32'(adr4),      m4.pc);
    check($sformatf("%s a", tag),      32'(dut4.a_q),  m4.a);
    check($sformatf("%s b", tag),      32'(dut4.b_q),  m4.b);
    check($sformatf("%s out", tag),    32'(out4),      m4.out);
    check($sformatf("%s c", tag),      32'(dut4.c_q),  m4.c);
    check($sformatf("%s halted", tag), 32'(halt4),     m4.h);
  endtask

  task automatic tick4(input string tag);
    int     ins;
    model_t nxt;
    ins = rom_mode ? int'(rom4[m4.pc[3:0]]) : int'(instr4);
    nxt = model_step(m4, ins, int'(in4), en4, rst4, 4, 4);
    @(posedge clk);
    #1;
    m4 = nxt;
    compare4(tag);
  endtask

  task automatic tick8();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom4(input logic [7:0] i0, input logic [7:0] i1,
                           input logic [7:0] i2, input logic [7:0] i3);
    for (int i = 0; i < 16; i++) rom4[i] = 8'hA0;
    rom4[0] = i0;
    rom4[1] = i1;
    rom4[2] = i2;
    rom4[3] = i3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h37, 4'h0, 1'b1,  1,  7, 0,  0, 0, 0};
    vecs[1]  = '{8'h09, 4'h0, 1'b1,  2,  0, 0,  0, 1, 0};
    vecs[2]  = '{8'hE5, 4'h0, 1'b1,  3,  0, 0,  0, 0, 0};
    vecs[3]  = '{8'hE9, 4'h0, 1'b1,  9,  0, 0,  0, 0, 0};
    vecs[4]  = '{8'h03, 4'h0, 1'b1, 10,  3, 0,  0, 0, 0};
    vecs[5]  = '{8'h40, 4'h0, 1'b1, 11,  3, 3,  0, 0, 0};
    vecs[6]  = '{8'h5E, 4'h0, 1'b1, 12,  3, 1,  0, 1, 0};
    vecs[7]  = '{8'hA0, 4'h0, 1'b0, 12,  3, 1,  0, 1, 0};
    vecs[8]  = '{8'hA0, 4'h0, 1'b1, 13,  3, 1,  0, 0, 0};
    vecs[9]  = '{8'h20, 4'hA, 1'b1, 14, 10, 1,  0, 0, 0};
    vecs[10] = '{8'h60, 4'h6, 1'b1, 15, 10, 6,  0, 0, 0};
    vecs[11] = '{8'h90, 4'h0, 1'b1,  0, 10, 6,  6, 0, 0};
    vecs[12] = '{8'h10, 4'h0, 1'b1,  1,  6, 6,  6, 0, 0};
    vecs[13] = '{8'hBC, 4'h0, 1'b1,  2,  6, 6, 12, 0, 0};
    vecs[14] = '{8'h72, 4'h0, 1'b1,  3,  6, 2, 12, 0, 0};
    vecs[15] = '{8'hF7, 4'h0, 1'b1,  7,  6, 2, 12, 0, 0};
    vecs[16] = '{8'hC0, 4'h0, 1'b1,  8,  6, 2, 12, 0, 0};
    vecs[17] = '{8'hD0, 4'h0, 1'b1,  9,  6, 2, 12, 0, 0};
    vecs[18] = '{8'h80, 4'h0, 1'b1,  9,  6, 2, 12, 0, 1};
    vecs[19] = '{8'h31, 4'h0, 1'b1,  9,  6, 2, 12, 0, 1};

    for (int i = 0; i < 16; i++) rom4[i] = 8'hA0;
    for (int i = 0; i < 64; i++) rom8[i] = 12'hA00;
    m4       = '{0, 0, 0, 0, 0, 0};
    rom_mode = 1'b0;
    instr4   = 8'hA0;
    in4      = 4'h0;
    en4      = 1'b1;
    rst4     = 1'b1;
    rst8     = 1'b1;
    en8      = 1'b1;
    in8      = 8'h00;

    // Reset state
    tick4("reset");
    rst4 = 1'b0;

    // Directed single-instruction vectors from the reset state
    for (int i = 0; i < 20; i++) begin
      instr4 = vecs[i].instr;
      in4    = vecs[i].inp;
      en4    = vecs[i].en;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d pc", i),     32'(adr4),     vecs[i].pc);
      check($sformatf("vec%0d a", i),      32'(dut4.a_q), vecs[i].a);
      check($sformatf("vec%0d b", i),      32'(dut4.b_q), vecs[i].b);
      check($sformatf("vec%0d out", i),    32'(out4),     vecs[i].out);
      check($sformatf("vec%0d c", i),      32'(dut4.c_q), vecs[i].c);
      check($sformatf("vec%0d halted", i), 32'(halt4),    vecs[i].h);
    end

    // OUT IM / IN B / OUT B / HLT program
    load_rom4(8'hBF, 8'h60, 8'h90, 8'h80);
    rom_mode = 1'b1;
    en4      = 1'b1;
    in4      = 4'h5;
    rst4     = 1'b1;
    tick4("io reset");
    rst4 = 1'b0;
    tick4("io e1");
    check("io out after edge1", 32'(out4), 15);
    tick4("io e2");
    tick4("io e3");
    check("io out after edge3", 32'(out4), 5);
    tick4("io e4");
    check("io halted after edge4", 32'(halt4), 1);
    check("io pc after edge4", 32'(adr4), 3);
    in4 = 4'h9;
    tick4("io halted hold1");
    en4 = 1'b0;
    tick4("io halted hold2");
    en4 = 1'b1;
    tick4("io halted hold3");
    check("io pc held while halted", 32'(adr4), 3);

    // Reset while halted and with en low restarts from address 0
    in4  = 4'h5;
    en4  = 1'b0;
    rst4 = 1'b1;
    tick4("halt reset");
    check("halt reset pc", 32'(adr4), 0);
    check("halt reset halted", 32'(halt4), 0);
    check("halt reset out", 32'(out4), 0);
    rst4 = 1'b0;
    en4  = 1'b1;
    tick4("rerun e1");
    check("rerun out after edge1", 32'(out4), 15);

    // Counter loop: ADD A,1 / JNC 0 / ADD B,1 / JMP 0
    load_rom4(8'h01, 8'hE0, 8'h51, 8'hF0);
    rst4 = 1'b1;
    tick4("loop reset");
    rst4 = 1'b0;
    repeat (30) tick4("loop");
    check("loop a before wrap", 32'(dut4.a_q), 15);
    check("loop pc before wrap", 32'(adr4), 0);
    tick4("loop e31");
    check("loop a wraps", 32'(dut4.a_q), 0);
    check("loop carry on wrap", 32'(dut4.c_q), 1);
    tick4("loop e32");
    check("loop jnc not taken", 32'(adr4), 2);
    tick4("loop e33");
    check("loop b incremented", 32'(dut4.b_q), 1);
    tick4("loop e34");
    check("loop back to 0", 32'(adr4), 0);

    // Same loop with a 3-cycle stall inserted
    rst4 = 1'b1;
    tick4("stall reset");
    rst4 = 1'b0;
    repeat (10) tick4("stall pre");
    en4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick4("stall");
      check($sformatf("stall%0d rom_adr", i), 32'(adr4), 0);
      check($sformatf("stall%0d a", i), 32'(dut4.a_q), 5);
    end
    en4 = 1'b1;
    repeat (24) tick4("stall post");
    check("stall result pc", 32'(adr4), 0);
    check("stall result a", 32'(dut4.a_q), 0);
    check("stall result b", 32'(dut4.b_q), 1);

    // Randomized instructions, enables and resets against the model
    rom_mode = 1'b0;
    rst4     = 1'b1;
    tick4("rand reset");
    for (int i = 0; i < 10000; i++) begin
      instr4 = 8'($urandom);
      in4    = 4'($urandom);
      en4    = ($urandom_range(0, 9) != 0);
      rst4   = ((m4.h != 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 499) == 0);
      tick4($sformatf("rand%0d", i));
    end
    rst4 = 1'b0;

    // DW=8, AW=6: carry out of 8 bits, JNC behaviour, PC wrap from 0x3F
    rom8[0]  = 12'h3FF;
    rom8[1]  = 12'h001;
    rom8[2]  = 12'hE10;
    rom8[3]  = 12'h305;
    rom8[4]  = 12'hE3F;
    rom8[63] = 12'hA00;
    rst8     = 1'b1;
    en8      = 1'b1;
    tick8();
    check("w8 reset pc", 32'(adr8), 0);
    check("w8 reset out", 32'(out8), 0);
    rst8 = 1'b0;
    tick8();
    check("w8 mov a ff", 32'(dut8.a_q), 255);
    tick8();
    check("w8 add wraps a", 32'(dut8.a_q), 0);
    check("w8 add carry", 32'(dut8.c_q), 1);
    tick8();
    check("w8 jnc not taken", 32'(adr8), 3);
    tick8();
    check("w8 mov a 05", 32'(dut8.a_q), 5);
    tick8();
    check("w8 jnc taken", 32'(adr8), 63);
    tick8();
    check("w8 pc wraps", 32'(adr8), 0);
    check("w8 not halted", 32'(halt8), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
